// File: rtl/serial_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serial_tx_pkg
// Brief   : Shared types and constants for the serial word transmitter.
//           Holds the frame FSM state encoding, default parameter values and
//           the gap-counter width.
// Revision: 1.0 - initial release
// ============================================================================
package serial_tx_pkg;

  // Frame sequencer states; encoding width is fixed so lint and synthesis agree.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_SHIFT = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_GAP   = 1;

  // Gap counter covers the full legal GAP range 0..15.
  localparam int GAP_CNT_W = 4;

endpackage : serial_tx_pkg
`default_nettype wire

// File: rtl/serial_neg_bit.sv
`default_nettype none
// ============================================================================
// Module  : serial_neg_bit
// Brief   : One-bit serial two's-complement stage. Passes bits up to and
//           including the first 1 of a frame, inverts every later bit.
//           clr starts a new frame; when clr and en coincide the current bit
//           is treated as the first bit of the new frame.
//           Built only when SERIAL_WORD_TX_NEGATE_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`ifdef SERIAL_WORD_TX_NEGATE_EN
module serial_neg_bit (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic b,
  output logic y
);
  import serial_tx_pkg::*;

  logic seen;

  // Remember whether a 1 has already passed in this frame.
  always_ff @(posedge clk) begin
    seen <= (clr ? 1'b0 : seen) | (en & b);
  end

  // A stale flag from the previous frame must not affect the first bit.
  assign y = b ^ (seen & ~clr);

endmodule : serial_neg_bit
`endif
`default_nettype wire

// File: rtl/serial_word_tx.sv
`default_nettype none
// ============================================================================
// Module  : serial_word_tx
// Brief   : Parallel-to-serial transmitter. Accepts a WIDTH-bit word on a
//           valid/ready handshake, emits a one-cycle frame-reset pulse on
//           ser_r, then the word LSB-first on ser_i, then GAP idle cycles.
//           All outputs are registered.
//           Option SERIAL_WORD_TX_NEGATE_EN adds input neg: when set with the
//           word, the stream is the two's complement of din.
// Revision: 1.0 - initial release
// ============================================================================
module serial_word_tx
  import serial_tx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int GAP   = DEFAULT_GAP
) (
  input  logic             t_clock,
  input  logic             r,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
`ifdef SERIAL_WORD_TX_NEGATE_EN
  input  logic             neg,
`endif
  output logic             din_ready,
  output logic             ser_i,
  output logic             ser_r,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]     BIT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);
  // With GAP=0 the frame returns straight to IDLE after the last bit.
  localparam state_t AFTER_SHIFT = (GAP == 0) ? S_IDLE : S_GAP;

  state_t                 state, state_n;
  logic [WIDTH-1:0]       sreg, sreg_n;
  logic [CNT_W-1:0]       bit_cnt, bit_cnt_n;
  logic [GAP_CNT_W-1:0]   gap_cnt, gap_cnt_n;

  logic ser_i_n, ser_r_n, ser_valid_n, din_ready_n, busy_n, done_n;
  logic shift_en;
  logic tx_bit;
  logic accept;

  assign accept = din_valid & din_ready;

`ifdef SERIAL_WORD_TX_NEGATE_EN
  logic neg_q, neg_q_n;
  logic neg_y;

  serial_neg_bit u_neg (
    .clk (t_clock),
    .clr (r | (state == S_START)),
    .en  (shift_en & ~r),
    .b   (sreg[0]),
    .y   (neg_y)
  );

  // Negation mode is latched with the word so a later change of neg is harmless.
  always_ff @(posedge t_clock) begin
    if (r) neg_q <= 1'b0;
    else   neg_q <= neg_q_n;
  end

  // Capture neg together with din on accept.
  always_comb begin
    neg_q_n = neg_q;
    if (state == S_IDLE && accept) neg_q_n = neg;
  end

  assign tx_bit = neg_q ? neg_y : sreg[0];
`else
  assign tx_bit = sreg[0];
`endif

  // State, datapath and registered outputs; reset also holds downstream cleared.
  always_ff @(posedge t_clock) begin
    if (r) begin
      state     <= S_IDLE;
      sreg      <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      ser_r     <= 1'b1;
      ser_i     <= 1'b0;
      ser_valid <= 1'b0;
      din_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      sreg      <= sreg_n;
      bit_cnt   <= bit_cnt_n;
      gap_cnt   <= gap_cnt_n;
      ser_r     <= ser_r_n;
      ser_i     <= ser_i_n;
      ser_valid <= ser_valid_n;
      din_ready <= din_ready_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  // Next-state and next-output logic; outputs are derived from the next state
  // so that the registered outputs line up with the state they describe.
  always_comb begin
    state_n   = state;
    sreg_n    = sreg;
    bit_cnt_n = bit_cnt;
    gap_cnt_n = gap_cnt;
    shift_en  = 1'b0;
    done_n    = 1'b0;
    ser_i_n   = 1'b0;

    case (state)
      S_IDLE: begin
        if (accept) begin
          state_n = S_START;
          sreg_n  = din;
        end
      end
      S_START: begin
        // Leaving START presents bit 0 in the first SHIFT cycle.
        state_n   = S_SHIFT;
        bit_cnt_n = '0;
        shift_en  = 1'b1;
      end
      S_SHIFT: begin
        if (bit_cnt == BIT_LAST) begin
          state_n   = AFTER_SHIFT;
          gap_cnt_n = '0;
          done_n    = 1'b1;
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
          shift_en  = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_n = S_IDLE;
        else                     gap_cnt_n = gap_cnt + 1'b1;
      end
      default: state_n = S_IDLE;
    endcase

    // Load the next serial bit into the output register and consume it.
    if (shift_en) begin
      ser_i_n = tx_bit;
      sreg_n  = {1'b0, sreg[WIDTH-1:1]};
    end

    ser_r_n     = (state_n == S_START);
    ser_valid_n = shift_en;
    din_ready_n = (state_n == S_IDLE);
    busy_n      = (state_n != S_IDLE);
  end

endmodule : serial_word_tx
`default_nettype wire

// File: tb/tb_serial_word_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_word_tx
// Brief   : Self-checking bench for serial_word_tx. Expected serial bits are
//           queued when a word is offered and popped whenever ser_valid is
//           seen. A GAP=1 instance covers framing, reset and busy behaviour;
//           a GAP=0 instance covers back-to-back frames.
// Revision: 1.0 - initial release
// ============================================================================
module tb_serial_word_tx;

  localparam int W = 8;

  logic         t_clock;
  logic         r;
  logic [W-1:0] din, din0;
  logic         din_valid, din_valid0;
  logic         neg_in;
  logic         din_ready, ser_i, ser_r, ser_valid, busy, done;
  logic         din_ready0, ser_i0, ser_r0, ser_valid0, busy0, done0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit q[$];
  bit q0[$];

  serial_word_tx #(.WIDTH(W), .GAP(1)) dut (
    .t_clock   (t_clock),
    .r         (r),
    .din       (din),
    .din_valid (din_valid),
`ifdef SERIAL_WORD_TX_NEGATE_EN
    .neg       (neg_in),
`endif
    .din_ready (din_ready),
    .ser_i     (ser_i),
    .ser_r     (ser_r),
    .ser_valid (ser_valid),
    .busy      (busy),
    .done      (done)
  );

  serial_word_tx #(.WIDTH(W), .GAP(0)) dut0 (
    .t_clock   (t_clock),
    .r         (r),
    .din       (din0),
    .din_valid (din_valid0),
`ifdef SERIAL_WORD_TX_NEGATE_EN
    .neg       (1'b0),
`endif
    .din_ready (din_ready0),
    .ser_i     (ser_i0),
    .ser_r     (ser_r0),
    .ser_valid (ser_valid0),
    .busy      (busy0),
    .done      (done0)
  );

  initial t_clock = 1'b0;
  always #5 t_clock = ~t_clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample 1 time unit after the edge, and score serial bits.
  task automatic tick();
    bit e;
    @(posedge t_clock);
    #1;
    cyc++;
    if (ser_valid === 1'b1) begin
      if (q.size() == 0) chk("unexpected_ser_valid", ser_valid, 1'b0);
      else begin
        e = q.pop_front();
        chk("ser_i", ser_i, e);
      end
    end
    if (ser_valid0 === 1'b1) begin
      if (q0.size() == 0) chk("unexpected_ser_valid0", ser_valid0, 1'b0);
      else begin
        e = q0.pop_front();
        chk("ser_i0", ser_i0, e);
      end
    end
  endtask

  // Send one word on the GAP=1 instance and check the full frame timing.
  task automatic send_frame(input logic [W-1:0] word, input logic negate,
                            input logic [W-1:0] expv, input bit poke);
    for (int n = 0; n < 20 && din_ready !== 1'b1; n++) tick();
    chk("ready_before_frame", din_ready, 1'b1);
    din       = word;
    neg_in    = negate;
    din_valid = 1'b1;
    for (int i = 0; i < W; i++) q.push_back(expv[i]);
    tick();
    din_valid = 1'b0;
    chk("start_ser_r", ser_r, 1'b1);
    chk("start_ser_valid", ser_valid, 1'b0);
    chk("start_ser_i", ser_i, 1'b0);
    chk("start_ready", din_ready, 1'b0);
    chk("start_busy", busy, 1'b1);
    for (int i = 0; i < W; i++) begin
      if (poke && i == 3) begin din = 8'h55; din_valid = 1'b1; end
      if (poke && i == 6) din_valid = 1'b0;
      tick();
      chk("bit_valid", ser_valid, 1'b1);
      chk("bit_ser_r_low", ser_r, 1'b0);
      chk("bit_no_done", done, 1'b0);
      if (poke) chk("busy_ready_low", din_ready, 1'b0);
    end
    tick();
    chk("done_pulse", done, 1'b1);
    chk("done_no_valid", ser_valid, 1'b0);
    chk("queue_drained", q.size(), 0);
    chk("gap_ready_low", din_ready, 1'b0);
    chk("gap_busy", busy, 1'b1);
    tick();
    chk("ready_after_gap", din_ready, 1'b1);
    chk("done_once", done, 1'b0);
    chk("idle_not_busy", busy, 1'b0);
  endtask

  initial begin
    int t0;
    int nvalid;
    int ndone;
    r = 1'b1; din = '0; din_valid = 1'b0; neg_in = 1'b0;
    din0 = '0; din_valid0 = 1'b0;

    // Reset held three cycles.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ser_r", ser_r, 1'b1);
      chk("rst_ready", din_ready, 1'b0);
      chk("rst_valid", ser_valid, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ser_r0", ser_r0, 1'b1);
    end
    r = 1'b0;
    tick();
    chk("post_rst_ready", din_ready, 1'b1);
    chk("post_rst_ser_r", ser_r, 1'b0);
    chk("post_rst_ready0", din_ready0, 1'b1);

    // Basic frame: B4 goes out as 0,0,1,0,1,1,0,1.
    send_frame(8'hB4, 1'b0, 8'hB4, 1'b0);
    send_frame(8'h5A, 1'b0, 8'h5A, 1'b0);

    // din_valid pulsed while busy is ignored.
    send_frame(8'hC3, 1'b0, 8'hC3, 1'b1);

    // Reset during bit 4 of AA aborts the frame.
    din = 8'hAA; din_valid = 1'b1;
    for (int i = 0; i < 5; i++) q.push_back(din[i]);
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("abort_in_bit4_valid", ser_valid, 1'b1);
    r = 1'b1;
    tick();
    chk("abort_ser_r", ser_r, 1'b1);
    chk("abort_no_valid", ser_valid, 1'b0);
    chk("abort_no_done", done, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_queue", q.size(), 0);
    r = 1'b0;
    tick();
    chk("abort_ready", din_ready, 1'b1);
    chk("abort_still_no_done", done, 1'b0);
    send_frame(8'h3C, 1'b0, 8'h3C, 1'b0);

    // Back-to-back frames on the GAP=0 instance.
    din0 = 8'h01; din_valid0 = 1'b1;
    for (int i = 0; i < W; i++) q0.push_back(din0[i]);
    tick();
    chk("b2b_first_ser_r", ser_r0, 1'b1);
    t0 = cyc;
    din0 = 8'hFF;
    for (int i = 0; i < W; i++) q0.push_back(din0[i]);
    nvalid = 0;
    ndone  = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (ser_r0 === 1'b1) break;
      if (ser_valid0 === 1'b1) nvalid++;
      if (done0 === 1'b1) ndone++;
    end
    din_valid0 = 1'b0;
    chk("b2b_period", cyc - t0, 10);
    chk("b2b_bits_between", nvalid, W);
    chk("b2b_done_between", ndone, 1);
    for (int i = 0; i < W; i++) tick();
    tick();
    chk("b2b_second_done", done0, 1'b1);
    chk("b2b_queue", q0.size(), 0);
    chk("b2b_ready", din_ready0, 1'b1);

`ifdef SERIAL_WORD_TX_NEGATE_EN
    // Two's-complement stream.
    send_frame(8'h06, 1'b1, 8'hFA, 1'b0);
    send_frame(8'h00, 1'b1, 8'h00, 1'b0);
    send_frame(8'h80, 1'b1, 8'h80, 1'b0);
    send_frame(8'h06, 1'b0, 8'h06, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_serial_word_tx
`default_nettype wire
